// File: rtl/apb_rr_arbiter.sv
// Round-robin APB master: shares one APB completer between NUM_REQ requesters,
// one SETUP/ACCESS transfer at a time. Optional ACCESS timeout: APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;
    logic                 pwrite_q, pwrite_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

    logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   grant_oh;
    logic [NUM_REQ-1:0]   eligible;
    logic [IDX_W-1:0]     ptr_inc;
    logic                 arb_found;
    logic [IDX_W-1:0]     arb_idx;
    int                   cand;
    logic [IDX_W-1:0]     cand_idx;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign grant_oh[gi]  = (grant_q == IDX_W'(gi));
        end
    endgenerate

    // A requester that is being answered this cycle has not yet had a chance
    // to drop or replace its request, so it sits out one arbitration round.
    assign eligible = req_valid & ~rsp_valid_q;
    assign ptr_inc  = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!arb_found && eligible[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
        rsp_err_d   = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d   = arb_idx;
                    paddr_d   = addr_arr[arb_idx];
                    pwdata_d  = wdata_arr[arb_idx];
                    pwrite_d  = req_write[arb_idx];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
`ifdef APB_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready is checked first so a completion on the last
                // permitted cycle beats the timeout.
                if (pready) begin
                    rsp_valid_d = grant_oh;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    ptr_d       = ptr_inc;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    tmo_cnt_d   = TMO_W'(TIMEOUT);
                    rsp_valid_d = grant_oh;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    ptr_d       = ptr_inc;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;

endmodule

// File: doc/apb_rr_arbiter.md
# apb_rr_arbiter

Round-robin APB master that shares one APB completer, the 256-word `apb_slave` memory, between `NUM_REQ` on-chip requesters. Each requester presents a simple valid/response transaction interface. The arbiter grants one requester at a time, runs a full APB SETUP/ACCESS transfer, waits for `pready`, and returns read data or completion to the granted requester. It sits between the requester fabric and the `apb_slave` port, on the `pclk` domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width.
- `TIMEOUT`, 16: ACCESS-cycle limit before abort. Used only with the timeout feature.

- `pclk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester transaction request.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  read data, qualified by `rsp_valid`.
- `rsp_err`  out  1  transfer aborted, qualified by `rsp_valid`.
- `paddr`  out  ADDR_W  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `pwdata`  out  DATA_W  APB write data.
- `pready`  in  1  APB completer ready.
- `prdata`  in  DATA_W  APB read data.

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is 0, so requester 0 has highest priority.
  - Timeout counter is 0.
- All outputs are registered.
- FSM states:
  - IDLE: if any eligible `req_valid` is set, grant the first set bit searching upward from the pointer, wrapping at `NUM_REQ-1`→0. Latch that requester's addr, wdata and write onto `paddr`/`pwdata`/`pwrite`, assert `psel`, go to SETUP. With no eligible request, stay in IDLE with `psel`=0.
  - SETUP: `psel`=1, `penable`=0. Always go to ACCESS next cycle.
  - ACCESS: `psel`=1, `penable`=1; hold until `pready`=1. On `pready`:
    - capture `prdata` (reads) or 0 (writes) into `rsp_rdata`;
    - pulse `rsp_valid[grant]` in the next cycle, with `rsp_err`=0;
    - set pointer = grant+1, mod `NUM_REQ`;
    - drop `psel`/`penable`; go to IDLE.
- Eligibility: in the IDLE cycle where `rsp_valid[i]`=1, requester i is masked. Requesters must drop `req_valid` or present the next transaction by the following cycle.
- `paddr`, `pwdata` and `pwrite` hold stable from SETUP through the end of ACCESS. Requester inputs are not re-sampled after grant.
- `req_valid` from other requesters during a transfer is held pending. It is served only through IDLE arbitration; there is no preemption.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0.
- Reset mid-transfer: the transfer is abandoned, `psel`/`penable` drop the next cycle, and no `rsp_valid` is issued.

## Timing
- A request sampled in IDLE at cycle T produces:
  - T+1: SETUP;
  - T+2: ACCESS;
  - T+3: `pready` from `apb_slave` (its registered ready);
  - T+4: `rsp_valid`, with the FSM in IDLE and arbitrating;
  - T+5: next `psel`, at the earliest.
- Minimum requester-to-response latency is 4 cycles. Back-to-back transfers occupy 4 cycles each.
- Additional wait states extend ACCESS one cycle per low-`pready` cycle.
- `rsp_valid` is always exactly one cycle wide and one-hot.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter increments on each ACCESS cycle with `pready`=0.
  - When it reaches `TIMEOUT`, the transfer aborts: `psel`/`penable` drop, `rsp_valid[grant]` pulses with `rsp_err`=1 and `rsp_rdata`=0, the pointer advances, and the FSM goes to IDLE.
  - The counter clears on entry to SETUP.
  - A `pready` that arrives in the same cycle the count reaches `TIMEOUT` wins, and the transfer completes normally.
- `APB_ARB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely; `rsp_err` is tied to 0.

## Test plan
- Single read after reset: requester 0 reads 0x10 → `psel` at T+1, `penable` at T+2, `rsp_valid`=4'b0001 at T+4, `rsp_rdata`=0x10 (slave reset content mem[i]=i), `rsp_err`=0.
- Write then read: requester 2 writes 0xDEADBEEF to 0x05, then reads 0x05 → two single-cycle `rsp_valid[2]` pulses; the read returns 0xDEADBEEF; `paddr` stays stable through each SETUP/ACCESS.
- Contention: all four `req_valid` held high, reads from 0x00..0x03 → grant order 0,1,2,3,0; each response carries its own data; transfers start 4 cycles apart.
- Wait states: hold `pready` low for 3 extra ACCESS cycles (stub completer) → ACCESS lasts 4 cycles; `psel`/`penable`/`paddr` stay stable; one `rsp_valid` pulse.
- Reset mid-transfer: assert `rst` during ACCESS → next cycle all outputs 0; no `rsp_valid`; the first post-reset grant goes to requester 0.
- Timeout (`APB_ARB_TIMEOUT_EN`, TIMEOUT=16): `pready` held 0 → abort after 16 ACCESS cycles, `rsp_valid[grant]` with `rsp_err`=1 and `rsp_rdata`=0; the next request completes normally.
